// File: rtl/vec_seq_capture.sv
// Drives a fixed 13-entry 4-bit stimulus table, holding each vector for DWELL
// cycles, and captures the device response bit at the last cycle of each vector.
module vec_seq_capture #(
  parameter int unsigned DWELL = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_in,
  output logic [3:0]  vec,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [12:0] resp
);

  localparam int unsigned NVEC       = 13;
  localparam logic [3:0]  LAST_IDX   = 4'(NVEC - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [12:0] resp_q, resp_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [3:0] vec_tab(input logic [3:0] i);
    case (i)
      4'd0:    vec_tab = 4'b0000;
      4'd1:    vec_tab = 4'b1000;
      4'd2:    vec_tab = 4'b0100;
      4'd3:    vec_tab = 4'b0010;
      4'd4:    vec_tab = 4'b0001;
      4'd5:    vec_tab = 4'b1100;
      4'd6:    vec_tab = 4'b1010;
      4'd7:    vec_tab = 4'b1001;
      4'd8:    vec_tab = 4'b0011;
      4'd9:    vec_tab = 4'b1110;
      4'd10:   vec_tab = 4'b0111;
      4'd11:   vec_tab = 4'b1011;
      4'd12:   vec_tab = 4'b1111;
      default: vec_tab = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        vec_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (start) begin
          state_d = DRIVE;
          busy_d  = 1'b1;
          vec_d   = vec_tab(4'd0);
          resp_d  = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          resp_d[idx_q] = s_in;
          cnt_d         = '0;
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 4'd1;
            vec_d = vec_tab(idx_q + 4'd1);
          end else begin
            // vec/idx hold the last vector through the DONE cycle
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec  = vec_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign resp = resp_q;

endmodule

// File: tb/tb_vec_seq_capture.sv
// Directed bench for vec_seq_capture: one instance at DWELL=50, one at DWELL=1,
// sharing clock and reset; s_in is either a constant or looped back from vec.
module tb_vec_seq_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start50 = 1'b0, start1 = 1'b0;
  logic        sin50_c = 1'b0, sin1_c = 1'b0;
  logic        sel50 = 1'b0, sel1 = 1'b0;
  logic        sin50, sin1;
  logic [3:0]  vec50, idx50, vec1, idx1;
  logic        busy50, done50, busy1, done1;
  logic [12:0] resp50, resp1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  assign sin50 = sel50 ? vec50[3] : sin50_c;
  assign sin1  = sel1  ? vec1[0]  : sin1_c;

  vec_seq_capture #(.DWELL(50)) u50 (
    .clk(clk), .rst(rst), .start(start50), .s_in(sin50),
    .vec(vec50), .idx(idx50), .busy(busy50), .done(done50), .resp(resp50)
  );

  vec_seq_capture #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .s_in(sin1),
    .vec(vec1), .idx(idx1), .busy(busy1), .done(done1), .resp(resp1)
  );

  function automatic logic [3:0] tab(input int i);
    logic [3:0] t [13];
    t = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b1010,
          4'b1001, 4'b0011, 4'b1110, 4'b0111, 4'b1011, 4'b1111};
    return t[i];
  endfunction

  // Expected capture word when s_in is looped back from vec bit 'b'.
  function automatic logic [12:0] loop_resp(input int b);
    logic [12:0] r;
    logic [3:0]  v;
    r = '0;
    for (int i = 0; i < 13; i++) begin
      v    = tab(i);
      r[i] = v[b];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle50(input string tag, input logic [12:0] r);
    chk({tag, ".busy"}, 32'(busy50), 32'd0);
    chk({tag, ".done"}, 32'(done50), 32'd0);
    chk({tag, ".vec"},  32'(vec50),  32'd0);
    chk({tag, ".idx"},  32'(idx50),  32'd0);
    chk({tag, ".resp"}, 32'(resp50), 32'(r));
  endtask

  // Start edge = edge 0; checks every edge through 651 (first IDLE cycle).
  task automatic run50(input string tag, input bit hold, input logic [12:0] exp_r);
    int i;
    start50 = 1'b1;
    step();
    if (!hold) start50 = 1'b0;
    chk({tag, ".e0busy"}, 32'(busy50), 32'd1);
    chk({tag, ".e0vec"},  32'(vec50),  32'(tab(0)));
    chk({tag, ".e0resp"}, 32'(resp50), 32'd0);
    for (int k = 1; k <= 650; k++) begin
      step();
      i = (k < 650) ? k / 50 : 12;
      chk({tag, ".vec"},  32'(vec50),  32'(tab(i)));
      chk({tag, ".idx"},  32'(idx50),  32'(i));
      chk({tag, ".busy"}, 32'(busy50), 32'(k < 650));
      chk({tag, ".done"}, 32'(done50), 32'(k == 650));
    end
    chk({tag, ".resp"}, 32'(resp50), 32'(exp_r));
    step();
    chk_idle50({tag, ".after"}, exp_r);
  endtask

  initial begin
    // Reset for two cycles, then ten idle cycles with start low.
    rst = 1'b1;
    step();
    step();
    chk_idle50("rst50", 13'h0);
    chk("rst1.busy", 32'(busy1), 32'd0);
    chk("rst1.resp", 32'(resp1), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_idle50("idle", 13'h0);
    end

    // Full run, s_in tied high.
    sin50_c = 1'b1;
    run50("run1", 1'b0, 13'h1FFF);

    // s_in looped back from vec[3] (a bit).
    sel50 = 1'b1;
    run50("runA", 1'b0, 13'h1AE2);
    chk("runA.model", 32'(resp50), 32'(loop_resp(3)));
    sel50 = 1'b0;

    // start held through the whole run: one run only, restart from IDLE clears resp.
    sin50_c = 1'b1;
    run50("hold", 1'b1, 13'h1FFF);
    step();
    chk("hold.restart.busy", 32'(busy50), 32'd1);
    chk("hold.restart.resp", 32'(resp50), 32'd0);
    chk("hold.restart.vec",  32'(vec50),  32'(tab(0)));
    start50 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle50("hold.rst", 13'h0);

    // Reset at edge 300 of a run; s_in toggles away from capture edges meanwhile.
    sin50_c = 1'b1;
    start50 = 1'b1;
    step();
    start50 = 1'b0;
    for (int k = 1; k < 300; k++) begin
      step();
      sin50_c = ((k % 50) == 48) ? 1'b1 : k[0];
    end
    chk("abort.pre.idx",  32'(idx50),  32'd5);
    chk("abort.pre.resp", 32'(resp50), 32'h001F);
    sin50_c = 1'b1;
    rst = 1'b1;
    start50 = 1'b1;
    step();
    rst = 1'b0;
    start50 = 1'b0;
    chk_idle50("abort", 13'h0);
    for (int k = 0; k < 60; k++) begin
      step();
      chk("abort.nodone", 32'(done50), 32'd0);
      chk("abort.noresume", 32'(busy50), 32'd0);
    end
    run50("rerun", 1'b0, 13'h1FFF);

    // DWELL=1: a new vector every edge, s_in looped back from vec[0] (d bit).
    sel1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("d1.e0vec", 32'(vec1), 32'(tab(0)));
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("d1.idx", 32'(idx1), 32'(k));
      chk("d1.vec", 32'(vec1), 32'(tab(k)));
      chk("d1.busy", 32'(busy1), 32'd1);
      chk("d1.done", 32'(done1), 32'd0);
    end
    step();
    chk("d1.done13", 32'(done1), 32'd1);
    chk("d1.busy13", 32'(busy1), 32'd0);
    chk("d1.idx13",  32'(idx1),  32'd12);
    chk("d1.resp",   32'(resp1), 32'(loop_resp(0)));
    step();
    chk("d1.after.done", 32'(done1), 32'd0);
    chk("d1.after.vec",  32'(vec1),  32'd0);
    chk("d1.after.resp", 32'(resp1), 32'(loop_resp(0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
